// File: rtl/pr_pkg.sv
// Shared types and constants for the parallel-to-serial parity framer.
package pr_pkg;

    // State encodings, also used as the enum values.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Parity mode selectors for the PAR_ODD parameter.
    localparam int unsigned PAR_EVEN    = 0;
    localparam int unsigned PAR_ODD_SEL = 1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } state_t;

endpackage : pr_pkg

// File: rtl/pr_serializer.sv
// Parallel-to-serial framer: accepts a DATA_W-bit word over valid/ready,
// shifts it out one bit per clock and appends one parity bit, so each
// DATA_W+1 bit frame has even (PAR_ODD=0) or odd (PAR_ODD=1) ones-count.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset
//   data_in    parallel word to serialize
//   data_valid data_in is valid this cycle
//   ready      block can accept a word (combinational from state)
//   sr_out     serial bit stream (registered)
//   sr_valid   sr_out carries a frame bit (registered)
//   sof        first data bit of a frame (registered)
//   par_slot   appended parity bit cycle (registered)
module pr_serializer
    import pr_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PAR_ODD   = 0,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              ready,
    output logic              sr_out,
    output logic              sr_valid,
    output logic              sof,
    output logic              par_slot
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             PAR_INV  = (PAR_ODD == PAR_ODD_SEL);
    localparam logic             MSB_SEL  = (MSB_FIRST != 0);

    // Bit presented next from a word, honoring the configured bit order.
    function automatic logic lead_bit(input logic [DATA_W-1:0] w);
        return MSB_SEL ? w[DATA_W-1] : w[0];
    endfunction

    // Word with its leading bit consumed.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return MSB_SEL ? (w << 1) : (w >> 1);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                sr_out_d, sr_valid_d, sof_d, par_slot_d;
    logic                accept;

    assign ready  = (state_q == IDLE) || (state_q == PARITY);
    assign accept = data_valid && ready;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            sr_out   <= 1'b0;
            sr_valid <= 1'b0;
            sof      <= 1'b0;
            par_slot <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            sr_out   <= sr_out_d;
            sr_valid <= sr_valid_d;
            sof      <= sof_d;
            par_slot <= par_slot_d;
        end
    end

    // Next state and next output values; outputs are one register stage
    // ahead, so the bit computed here is visible the cycle after.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        sr_out_d   = 1'b0;
        sr_valid_d = 1'b0;
        sof_d      = 1'b0;
        par_slot_d = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                sr_valid_d = 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d    = PARITY;
                    sr_out_d   = par_q;
                    par_slot_d = 1'b1;
                end else begin
                    sr_out_d = lead_bit(shreg_q);
                    shreg_d  = shift_word(shreg_q);
                    count_d  = count_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides IDLE/PARITY fallthrough: first bit goes out next cycle.
        if (accept) begin
            state_d    = SHIFT;
            count_d    = '0;
            shreg_d    = shift_word(data_in);
            par_d      = (^data_in) ^ PAR_INV;
            sr_out_d   = lead_bit(data_in);
            sr_valid_d = 1'b1;
            sof_d      = 1'b1;
        end
    end

endmodule : pr_serializer

// File: tb/tb_pr_serializer.sv
// Directed bench for pr_serializer: three configurations driven side by side,
// each feeding a small running-XOR parity detector stand-in.
module tb_pr_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       dv    [3];
    logic       rdy   [3];
    logic       so    [3];
    logic       sv    [3];
    logic       sof_w [3];
    logic       ps    [3];
    logic       det   [3];

    int total;
    int bad;

    // u0: even, LSB first; u1: odd, LSB first; u2: odd, MSB first
    pr_serializer #(.DATA_W(8), .PAR_ODD(0), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv[0]), .ready(rdy[0]),
        .sr_out(so[0]), .sr_valid(sv[0]), .sof(sof_w[0]), .par_slot(ps[0]));
    pr_serializer #(.DATA_W(8), .PAR_ODD(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv[1]), .ready(rdy[1]),
        .sr_out(so[1]), .sr_valid(sv[1]), .sof(sof_w[1]), .par_slot(ps[1]));
    pr_serializer #(.DATA_W(8), .PAR_ODD(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv[2]), .ready(rdy[2]),
        .sr_out(so[2]), .sr_valid(sv[2]), .sof(sof_w[2]), .par_slot(ps[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream serial parity detector stand-in: running XOR of the stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det[0] <= 1'b0;
            det[1] <= 1'b0;
            det[2] <= 1'b0;
        end else begin
            det[0] <= det[0] ^ so[0];
            det[1] <= det[1] ^ so[1];
            det[2] <= det[2] ^ so[2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Send one word on instance idx; seq[i] is the i-th bit expected on sr_out.
    task automatic send_frame(input int idx, input logic [7:0] word,
                              input logic [7:0] seq, input logic par, input string tag);
        @(negedge clk);
        data_in = word;
        dv[idx] = 1'b1;
        chk({tag, " ready_pre"}, 32'(rdy[idx]), 32'd1);
        @(negedge clk);
        dv[idx] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s bit%0d", tag, i), 32'(so[idx]), 32'(seq[i]));
            chk($sformatf("%s vld%0d", tag, i), 32'(sv[idx]), 32'd1);
            chk($sformatf("%s sof%0d", tag, i), 32'(sof_w[idx]), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s ps%0d", tag, i), 32'(ps[idx]), 32'd0);
            chk($sformatf("%s rdy%0d", tag, i), 32'(rdy[idx]), 32'd0);
            @(negedge clk);
        end
        chk({tag, " par"}, 32'(so[idx]), 32'(par));
        chk({tag, " par_slot"}, 32'(ps[idx]), 32'd1);
        chk({tag, " par_vld"}, 32'(sv[idx]), 32'd1);
        chk({tag, " par_sof"}, 32'(sof_w[idx]), 32'd0);
        chk({tag, " par_rdy"}, 32'(rdy[idx]), 32'd1);
        @(negedge clk);
        chk({tag, " idle_vld"}, 32'(sv[idx]), 32'd0);
        chk({tag, " idle_out"}, 32'(so[idx]), 32'd0);
        chk({tag, " idle_rdy"}, 32'(rdy[idx]), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [17:0] b2b_seq;
    logic [17:0] b2b_sof;
    logic [17:0] b2b_ps;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k < 3; k++) dv[k] = 1'b0;

        // 1: reset state, then idle after release with data_valid low
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dv[0] = 1'b1;  // ignored while in reset
            chk("rst_vld", 32'(sv[0]), 32'd0);
            chk("rst_out", 32'(so[0]), 32'd0);
            chk("rst_sof", 32'(sof_w[0]), 32'd0);
            chk("rst_ps",  32'(ps[0]), 32'd0);
            chk("rst_rdy", 32'(rdy[0]), 32'd1);
        end
        dv[0] = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(sv[0]), 32'd0);
            chk("post_rst_out", 32'(so[0]), 32'd0);
            chk("post_rst_rdy", 32'(rdy[0]), 32'd1);
        end

        // 2: even parity, LSB first, A5 -> 1,0,1,0,0,1,0,1 then 0
        send_frame(0, 8'hA5, 8'b1010_0101, 1'b0, "a5_even");

        // 3: odd parity, 07 -> 1,1,1,0,0,0,0,0 then 0; MSB first 01 -> 0..0,1 then 0
        send_frame(1, 8'h07, 8'b0000_0111, 1'b0, "07_odd");
        send_frame(2, 8'h01, 8'b1000_0000, 1'b0, "01_msb");

        // 4: back-to-back FF then 01, no gap; data_in changes while busy are ignored
        b2b_seq = 18'b10_0000_0010_1111_1111;
        b2b_sof = 18'b00_0000_0010_0000_0001;
        b2b_ps  = 18'b10_0000_0001_0000_0000;
        @(negedge clk);
        data_in = 8'hFF;
        dv[0]   = 1'b1;
        @(negedge clk);
        data_in = 8'h01;
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("b2b vld%0d", i), 32'(sv[0]), 32'd1);
            chk($sformatf("b2b out%0d", i), 32'(so[0]), 32'(b2b_seq[i]));
            chk($sformatf("b2b sof%0d", i), 32'(sof_w[0]), 32'(b2b_sof[i]));
            chk($sformatf("b2b ps%0d", i),  32'(ps[0]), 32'(b2b_ps[i]));
            if (i == 4) data_in = 8'h55;  // not ready: must not disturb FF frame
            if (i == 8) data_in = 8'h01;
            if (i >= 9) dv[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b end_vld", 32'(sv[0]), 32'd0);

        // 5: async reset during 4th data bit of C3, then a clean 3C frame
        @(negedge clk);
        data_in = 8'hC3;
        dv[0]   = 1'b1;
        @(negedge clk);
        dv[0]   = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("c3 bit3_pre", 32'(so[0]), 32'd0);
        chk("c3 vld_pre",  32'(sv[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(sv[0]), 32'd0);
        chk("mid_rst_out", 32'(so[0]), 32'd0);
        chk("mid_rst_rdy", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("abandon_vld", 32'(sv[0]), 32'd0);
            chk("abandon_ps",  32'(ps[0]), 32'd0);
        end
        send_frame(0, 8'h3C, 8'b0011_1100, 1'b0, "3c_even");

        // 6: chained detector, even then odd
        pulse_reset();
        send_frame(0, 8'hA5, 8'b1010_0101, 1'b0, "ch_e_a5");
        chk("det_even_a5", 32'(det[0]), 32'd0);
        send_frame(0, 8'h3C, 8'b0011_1100, 1'b0, "ch_e_3c");
        chk("det_even_3c", 32'(det[0]), 32'd0);
        send_frame(0, 8'h81, 8'b1000_0001, 1'b0, "ch_e_81");
        chk("det_even_81", 32'(det[0]), 32'd0);
        send_frame(1, 8'hA5, 8'b1010_0101, 1'b1, "ch_o_a5");
        chk("det_odd_a5", 32'(det[1]), 32'd1);
        send_frame(1, 8'h3C, 8'b0011_1100, 1'b1, "ch_o_3c");
        chk("det_odd_3c", 32'(det[1]), 32'd0);
        send_frame(1, 8'h81, 8'b1000_0001, 1'b1, "ch_o_81");
        chk("det_odd_81", 32'(det[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pr_serializer

// File: doc/pr_serializer.md
Name: pr_serializer

Overview:
Parallel-to-serial framer that sits directly upstream of the serial parity detector and drives its serial input.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Shifts the word out one bit per clock, then appends one generated parity bit.
- Every frame of DATA_W+1 bits therefore has even or odd total parity, depending on configuration.
- Frame-marker outputs let downstream logic locate frame boundaries.

Parameters:
- DATA_W, 8, payload bits per frame; legal range 2..32.
- PAR_ODD, 0, 0: appended bit makes the frame's ones-count even; 1: makes it odd.
- MSB_FIRST, 0, 0: data shifted LSB first; 1: MSB first.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  parallel word to serialize.
- data_valid  input  1  data_in is valid this cycle.
- ready  output  1  block can accept a word this cycle.
- sr_out  output  1  serial bit stream; feeds the parity detector's serial input.
- sr_valid  output  1  sr_out carries a frame bit (data or parity).
- sof  output  1  high on the first data bit of a frame.
- par_slot  output  1  high on the appended parity-bit cycle.

Behaviour:
- Reset is asynchronous, active-low.
  - While rst is low: state=IDLE; shift register, bit counter and parity register cleared.
  - While rst is low: sr_out=0, sr_valid=0, sof=0, par_slot=0, ready=1.
  - data_valid is ignored while rst is low.
- sr_out, sr_valid, sof and par_slot are registered outputs.
- ready is combinational from state: ready = (state==IDLE) || (state==PARITY).
- Handshake:
  - A word is accepted on a posedge where data_valid && ready.
  - data_in is captured into the shift register on that edge.
  - Parity is computed from the captured word as XOR-reduce(data_in) ^ PAR_ODD.
- FSM states:
  - IDLE: on accept, go to SHIFT with count=0.
  - SHIFT: one data bit is presented per cycle; count increments; at count==DATA_W-1, go to PARITY.
  - PARITY: the parity bit is presented.
    - If data_valid (accept), go to SHIFT with count=0 and the new word loaded.
    - Otherwise go to IDLE.
- Latency and throughput:
  - The first data bit appears on sr_out in the cycle after the accept edge, with sof=1 and sr_valid=1.
  - Data bits occupy DATA_W consecutive cycles; the parity bit follows immediately with par_slot=1.
  - Back-to-back words produce no idle gap: one frame per DATA_W+1 cycles, with sr_valid held high continuously.
- Bit order:
  - MSB_FIRST=0: bit 0 first.
  - MSB_FIRST=1: bit DATA_W-1 first.
- Idle outputs: in IDLE, sr_out=0 and sr_valid=0. The downstream detector then sees zeros and holds its parity.
- sof and par_slot are never high together; both are 0 when sr_valid=0.
- Counter: width $clog2(DATA_W); it never exceeds DATA_W-1 and has no wrap beyond the PARITY transition.
- Reset mid-frame: the frame is abandoned, outputs go to reset values immediately, and no partial parity bit is emitted.
- data_in changes while not ready have no effect. data_valid held high with no accept opportunity is simply waited on; there is no drop or overflow path.
- Downstream contract:
  - PAR_ODD=0: each complete frame leaves the detector's output unchanged.
  - PAR_ODD=1: each complete frame toggles the detector's output.

Decomposition:
- Shared package pr_pkg:
  - FSM state typedef (IDLE, SHIFT, PARITY) as a 2-bit logic type.
  - Named localparams for the state encodings.
  - Constants PAR_EVEN=0 and PAR_ODD_SEL=1.
- No sub-module required; shift register, counter and FSM live in one module.
- The bench instantiates the existing parity detector downstream for the chained scenario.

Test Plan:
1. Assert rst low for 3 cycles, then release with data_valid=0 -> sr_out=0, sr_valid=0, sof=0, par_slot=0, ready=1 throughout.
2. PAR_ODD=0, MSB_FIRST=0, accept 8'hA5 -> sr_out = 1,0,1,0,0,1,0,1 then parity 0.
   - sof on the first bit; par_slot and ready high on the 9th bit; then IDLE.
3. PAR_ODD=1, accept 8'h07 -> bits 1,1,1,0,0,0,0,0 then parity 0 (frame ones-count 3).
   - MSB_FIRST=1 with 8'h01 -> 0,0,0,0,0,0,0,1 then parity 0.
4. PAR_ODD=0, data_valid held with 8'hFF then 8'h01 -> 18 consecutive sr_valid cycles.
   - Parity bits are 0 then 1; sof on cycles 1 and 10; no gap.
5. Assert rst low during the 4th data bit of 8'hC3 -> sr_valid and sr_out drop to 0 asynchronously, with no parity bit.
   - After release, 8'h3C is sent as a complete frame with parity 0.
6. Chained with the detector, PAR_ODD=0, frames 8'hA5, 8'h3C, 8'h81 -> detector output 0 after each par_slot cycle.
   - With PAR_ODD=1, the detector output toggles 1,0,1 after each frame.
